// File: rtl/denormalize.sv
// denormalize: output packing stage of the FP16 square-root datapath.
// Turns an unbiased exponent, a normalized significand with guard bits, a
// sign and special-class flags into an IEEE-754 binary16 word using
// round-to-nearest-even, gradual underflow, overflow to infinity and
// canonical specials. Two register stages.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       pipeline enable; low synchronously clears every stage register
//   in_valid     input word valid
//   is_num       finite number (zero when mant_in == 0)
//   is_nan       NaN
//   is_pinf      +inf
//   is_ninf      -inf
//   sign_in      sign
//   exp_in       signed unbiased exponent (-64..63)
//   mant_in      significand, MSB is the leading one when nonzero
//   out_valid    result valid, one pulse per accepted input
//   result       packed binary16
//   out_inexact  rounding discarded nonzero bits
//   out_overflow finite input rounded to infinity
//
// Valid semantics: no backpressure. A word is accepted on every rising edge
// where enable & in_valid; it leaves as a one-cycle out_valid pulse two edges
// later. Data registers hold while no word is loaded, so result/flags keep the
// last value while out_valid is low, except after reset or enable low (zeros).
module denormalize #(
  parameter int MANT_W = 14,
  parameter int BIAS   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic              is_num,
  input  logic              is_nan,
  input  logic              is_pinf,
  input  logic              is_ninf,
  input  logic              sign_in,
  input  logic [6:0]        exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              out_valid,
  output logic [15:0]       result,
  output logic              out_inexact,
  output logic              out_overflow
);

  localparam int         EXT_W  = 2 * MANT_W + 1;
  localparam logic [7:0] BIAS_B = 8'(BIAS);
  localparam logic [7:0] SH_MAX = 8'(MANT_W + 1);

  typedef enum logic [2:0] {
    CLS_NUM,
    CLS_ZERO,
    CLS_NAN,
    CLS_PINF,
    CLS_NINF
  } cls_t;

  // ---------------- stage 1: classify, bias, subnormal alignment ----------
  cls_t             cls_d;
  logic [7:0]       be;
  logic             be_le0;
  logic             be_big;
  logic [7:0]       sh_raw;
  logic [7:0]       sh;
  logic [EXT_W-1:0] ext;
  logic [MANT_W-1:0] aligned;
  logic [9:0]       frac_d;
  logic             g_d;
  logic             s_d;
  logic [4:0]       exp_d;

  always_comb begin
    cls_d = CLS_NAN;
    if (is_nan)       cls_d = CLS_NAN;
    else if (is_pinf) cls_d = CLS_PINF;
    else if (is_ninf) cls_d = CLS_NINF;
    else if (is_num)  cls_d = (mant_in == '0) ? CLS_ZERO : CLS_NUM;
  end

  always_comb begin
    // 8-bit two's complement: exp_in sign-extended plus the bias.
    be     = {exp_in[6], exp_in} + BIAS_B;
    be_le0 = be[7] | (be == 8'd0);
    be_big = !be[7] && (be >= 8'd31);
    sh_raw = 8'd1 - be;
    sh     = 8'd0;
    if (be_le0) sh = (sh_raw > SH_MAX) ? SH_MAX : sh_raw;
    // The lower MANT_W+1 bits catch everything shifted out; at the clamp the
    // whole significand lands there and becomes sticky.
    ext     = {mant_in, {(MANT_W + 1){1'b0}}} >> sh;
    aligned = ext[EXT_W-1 -: MANT_W];
    // The leading significand bit is implied by the exponent field (1 for
    // normals, 0 after a subnormal shift), so only the fraction is kept.
    frac_d  = aligned[MANT_W-2 -: 10];
    g_d     = aligned[MANT_W-12];
    s_d     = (|aligned[MANT_W-13:0]) | (|ext[MANT_W:0]);
    exp_d   = be_le0 ? 5'd0 : be[4:0];
  end

  logic       s1_valid;
  cls_t       s1_cls;
  logic       s1_sign;
  logic [4:0] s1_exp;
  logic [9:0] s1_frac;
  logic       s1_g;
  logic       s1_s;
  logic       s1_big;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_NUM;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_big   <= 1'b0;
    end else if (!enable) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_NUM;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_big   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cls  <= cls_d;
        s1_sign <= sign_in;
        s1_exp  <= exp_d;
        s1_frac <= frac_d;
        s1_g    <= g_d;
        s1_s    <= s_d;
        s1_big  <= be_big;
      end
    end
  end

  // ---------------- stage 2: round to nearest even, pack ------------------
  logic        round_up;
  logic [15:0] packed_sum;
  logic        ovf;
  logic [15:0] res_d;
  logic        inexact_d;
  logic        overflow_d;

  always_comb begin
    round_up = s1_g & (s1_s | s1_frac[0]);
    // Adding into {exp, frac} lets a fraction carry bump the exponent; a
    // subnormal rounding up to 0x400 becomes exponent field 1 on its own.
    packed_sum = {1'b0, s1_exp, s1_frac} + {15'd0, round_up};
    ovf        = s1_big | (packed_sum[15:10] >= 6'd31);
    res_d      = 16'h7E00;
    inexact_d  = 1'b0;
    overflow_d = 1'b0;
    case (s1_cls)
      CLS_NUM: begin
        inexact_d = s1_g | s1_s;
        if (ovf) begin
          res_d      = {s1_sign, 5'h1F, 10'h000};
          overflow_d = 1'b1;
        end else begin
          res_d = {s1_sign, packed_sum[14:0]};
        end
      end
      CLS_ZERO: res_d = {s1_sign, 15'h0000};
      CLS_PINF: res_d = 16'h7C00;
      CLS_NINF: res_d = 16'hFC00;
      default:  res_d = 16'h7E00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      result       <= 16'h0000;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (!enable) begin
      out_valid    <= 1'b0;
      result       <= 16'h0000;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result       <= res_d;
        out_inexact  <= inexact_d;
        out_overflow <= overflow_d;
      end
    end
  end

endmodule

// File: tb/tb_denormalize.sv
// Directed bench for denormalize (MANT_W=14, BIAS=15). Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
module tb_denormalize;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic        is_num;
  logic        is_nan;
  logic        is_pinf;
  logic        is_ninf;
  logic        sign_in;
  logic [6:0]  exp_in;
  logic [13:0] mant_in;
  logic        out_valid;
  logic [15:0] result;
  logic        out_inexact;
  logic        out_overflow;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  localparam logic [3:0] F_NUM  = 4'b0001;
  localparam logic [3:0] F_NINF = 4'b0010;
  localparam logic [3:0] F_PINF = 4'b0100;
  localparam logic [3:0] F_NAN  = 4'b1000;

  denormalize #(.MANT_W(14), .BIAS(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .is_num       (is_num),
    .is_nan       (is_nan),
    .is_pinf      (is_pinf),
    .is_ninf      (is_ninf),
    .sign_in      (sign_in),
    .exp_in       (exp_in),
    .mant_in      (mant_in),
    .out_valid    (out_valid),
    .result       (result),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic vld, input logic [3:0] flg, input logic sgn,
                       input logic [6:0] e, input logic [13:0] m);
    in_valid = vld;
    {is_nan, is_pinf, is_ninf, is_num} = flg;
    sign_in = sgn;
    exp_in  = e;
    mant_in = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word through an empty pipeline: no output after the first edge, the
  // result after the second.
  task automatic vec(input string tag, input logic [3:0] flg, input logic sgn,
                     input logic [6:0] e, input logic [13:0] m,
                     input logic [15:0] er, input logic ei, input logic eo);
    drive(1'b1, flg, sgn, e, m);
    step();
    drive(1'b0, F_NUM, 1'b0, 7'd0, 14'd0);
    check({tag, " lat"}, {15'd0, out_valid}, 16'd0);
    step();
    check({tag, " vld"}, {15'd0, out_valid}, 16'd1);
    check({tag, " res"}, result, er);
    check({tag, " inx"}, {15'd0, out_inexact}, {15'd0, ei});
    check({tag, " ovf"}, {15'd0, out_overflow}, {15'd0, eo});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    drive(1'b0, F_NUM, 1'b0, 7'd0, 14'd0);
    #2;
    check("rst vld", {15'd0, out_valid}, 16'd0);
    check("rst res", result, 16'h0000);
    check("rst inx", {15'd0, out_inexact}, 16'd0);
    check("rst ovf", {15'd0, out_overflow}, 16'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic value and round-to-nearest-even.
    vec("one",      F_NUM, 1'b0, 7'd0, 14'h2000, 16'h3C00, 1'b0, 1'b0);
    check("hold vld", {15'd0, out_valid}, 16'd1);
    step();
    check("hold vld0", {15'd0, out_valid}, 16'd0);
    check("hold res", result, 16'h3C00);
    vec("tie_even", F_NUM, 1'b0, 7'd0, 14'h2004, 16'h3C00, 1'b1, 1'b0);
    vec("tie_odd",  F_NUM, 1'b0, 7'd0, 14'h200C, 16'h3C02, 1'b1, 1'b0);
    vec("above",    F_NUM, 1'b0, 7'd0, 14'h2005, 16'h3C01, 1'b1, 1'b0);

    // Overflow region: be=30 with carry, max finite, be=31, negative.
    vec("ovf_carry", F_NUM, 1'b0, 7'd15, 14'h3FFF, 16'h7C00, 1'b1, 1'b1);
    vec("max_fin",   F_NUM, 1'b0, 7'd15, 14'h3FF8, 16'h7BFF, 1'b0, 1'b0);
    vec("ovf_big",   F_NUM, 1'b0, 7'd16, 14'h2000, 16'h7C00, 1'b0, 1'b1);
    vec("ovf_neg",   F_NUM, 1'b1, 7'd16, 14'h2000, 16'hFC00, 1'b0, 1'b1);

    // Underflow: be=0 shifts by one; deep shifts collapse into sticky.
    vec("be0",       F_NUM, 1'b0, -7'sd15, 14'h2000, 16'h0200, 1'b0, 1'b0);
    vec("min_sub",   F_NUM, 1'b0, -7'sd24, 14'h2000, 16'h0001, 1'b0, 1'b0);
    vec("half_min",  F_NUM, 1'b0, -7'sd25, 14'h2000, 16'h0000, 1'b1, 1'b0);
    vec("half_up",   F_NUM, 1'b0, -7'sd25, 14'h2001, 16'h0001, 1'b1, 1'b0);
    // Largest subnormal-range input rounds up into the smallest normal.
    vec("sub_to_n",  F_NUM, 1'b0, -7'sd15, 14'h3FFF, 16'h0400, 1'b1, 1'b0);
    // be=1 is already normal: 1.111..b x 2^-14 rounds to 2^-13.
    vec("n_carry",   F_NUM, 1'b0, -7'sd14, 14'h3FFF, 16'h0800, 1'b1, 1'b0);
    vec("clamp",     F_NUM, 1'b0, -7'sd60, 14'h2000, 16'h0000, 1'b1, 1'b0);

    // Specials, priority and zero.
    vec("nan",       F_NAN,          1'b1, 7'd3,  14'h2000, 16'h7E00, 1'b0, 1'b0);
    vec("pinf",      F_PINF,         1'b1, 7'd0,  14'h0000, 16'h7C00, 1'b0, 1'b0);
    vec("ninf",      F_NINF,         1'b0, 7'd0,  14'h0000, 16'hFC00, 1'b0, 1'b0);
    vec("noflag",    4'b0000,        1'b0, 7'd0,  14'h2000, 16'h7E00, 1'b0, 1'b0);
    vec("pri_nan",   F_NAN | F_NUM,  1'b0, 7'd0,  14'h2000, 16'h7E00, 1'b0, 1'b0);
    vec("pri_inf",   F_PINF | F_NINF,1'b0, 7'd0,  14'h0000, 16'h7C00, 1'b0, 1'b0);
    vec("neg_zero",  F_NUM,          1'b1, 7'd20, 14'h0000, 16'h8000, 1'b0, 1'b0);

    // Back-to-back stream of five words.
    begin
      logic [6:0]  s_e[5];
      logic [13:0] s_m[5];
      logic        s_s[5];
      s_e = '{7'd0, 7'd1, -7'sd1, 7'd0, 7'd0};
      s_m = '{14'h2000, 14'h2000, 14'h2000, 14'h2008, 14'h2000};
      s_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      exp_q.push_back(16'h3C00);
      exp_q.push_back(16'h4000);
      exp_q.push_back(16'h3800);
      exp_q.push_back(16'h3C01);
      exp_q.push_back(16'hBC00);
      for (int c = 0; c < 7; c++) begin
        if (c < 5) drive(1'b1, F_NUM, s_s[c], s_e[c], s_m[c]);
        else       drive(1'b0, F_NUM, 1'b0, 7'd0, 14'd0);
        step();
        if (c >= 1 && c <= 5) begin
          check($sformatf("strm%0d vld", c - 1), {15'd0, out_valid}, 16'd1);
          if (exp_q.size() > 0) check($sformatf("strm%0d res", c - 1), result, exp_q.pop_front());
        end
      end
      check("strm end vld", {15'd0, out_valid}, 16'd0);
      check("strm q empty", 16'(exp_q.size()), 16'd0);
    end

    // Enable dropped with two words in flight (one in stage 1, one at input).
    drive(1'b1, F_NUM, 1'b0, 7'd15, 14'h3FFF);
    step();
    drive(1'b1, F_NUM, 1'b0, 7'd0, 14'h2005);
    enable = 1'b0;
    step();
    drive(1'b0, F_NUM, 1'b0, 7'd0, 14'd0);
    enable = 1'b1;
    check("en vld", {15'd0, out_valid}, 16'd0);
    check("en res", result, 16'h0000);
    check("en ovf", {15'd0, out_overflow}, 16'd0);
    check("en inx", {15'd0, out_inexact}, 16'd0);
    step();
    check("en after1", {15'd0, out_valid}, 16'd0);
    step();
    check("en after2", {15'd0, out_valid}, 16'd0);

    // Asynchronous reset mid-cycle with held nonzero outputs and a word in
    // stage 1.
    vec("pre_rst", F_NUM, 1'b0, 7'd15, 14'h3FFF, 16'h7C00, 1'b1, 1'b1);
    drive(1'b1, F_NUM, 1'b0, 7'd0, 14'h2005);
    step();
    drive(1'b0, F_NUM, 1'b0, 7'd0, 14'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst vld", {15'd0, out_valid}, 16'd0);
    check("arst res", result, 16'h0000);
    check("arst inx", {15'd0, out_inexact}, 16'd0);
    check("arst ovf", {15'd0, out_overflow}, 16'd0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post_rst%0d vld", c), {15'd0, out_valid}, 16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything beyond this is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
